// File: rtl/frame_pixel_source.sv
// rtl/frame_pixel_source.sv - raster-driven test-pattern responder for the pixel-stream framebuffer port
module frame_pixel_source #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int GRAD_SHIFT = 3,
  parameter int CHK_BIT    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_next_pixel_in,
  input  logic       frame_reset_in,
  input  logic [2:0] pattern_sel,
  input  logic [3:0] solid_level,
  output logic [3:0] frame_pixel_out,
  output logic       frame_done
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic          nxt_s1, nxt_s2, nxt_s3;
  logic          rst_s1, rst_s2;
  logic          adv, rst_frm;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [3:0]    frame_cnt;
  logic          x_last, y_last;
  logic [31:0]   xe, ye;
  logic [3:0]    pix_next;

  // Bring the strobe and restart level into clk; s3 gives the strobe's previous synchronised value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nxt_s1 <= 1'b0;
      nxt_s2 <= 1'b0;
      nxt_s3 <= 1'b0;
      rst_s1 <= 1'b0;
      rst_s2 <= 1'b0;
    end else begin
      nxt_s1 <= frame_next_pixel_in;
      nxt_s2 <= nxt_s1;
      nxt_s3 <= nxt_s2;
      rst_s1 <= frame_reset_in;
      rst_s2 <= rst_s1;
    end
  end

  assign adv     = nxt_s2 & ~nxt_s3;
  assign rst_frm = rst_s2;
  assign x_last  = (x == XW'(WIDTH - 1));
  assign y_last  = (y == YW'(HEIGHT - 1));

  // Raster walk: restart beats advance; a wrap from the last pixel bumps the frame count and pulses done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x          <= '0;
      y          <= '0;
      frame_cnt  <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (rst_frm) begin
        x <= '0;
        y <= '0;
      end else if (adv) begin
        if (!x_last) begin
          x <= x + 1'b1;
        end else begin
          x <= '0;
          if (!y_last) begin
            y <= y + 1'b1;
          end else begin
            y          <= '0;
            frame_cnt  <= frame_cnt + 4'h1;
            frame_done <= 1'b1;
          end
        end
      end
    end
  end

  // Pattern generator for the current raster position; every result is truncated to 4 bits
  always_comb begin
    xe       = 32'(x);
    ye       = 32'(y);
    pix_next = 4'h0;
    case (pattern_sel)
      3'd0: pix_next = solid_level;
      3'd1: pix_next = 4'(xe >> GRAD_SHIFT);
      3'd2: pix_next = 4'(ye >> GRAD_SHIFT);
      3'd3: pix_next = (xe[CHK_BIT] ^ ye[CHK_BIT]) ? 4'hF : 4'h0;
      3'd4: pix_next = 4'(xe + ye + 32'(frame_cnt));
      3'd5: pix_next = ((x == '0) || x_last || (y == '0) || y_last) ? 4'hF : 4'h0;
      3'd6: pix_next = 4'(xe ^ ye);
      3'd7: pix_next = ~solid_level;
    endcase
  end

  // Output pixel register, reloaded every cycle so select/level changes show after one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_pixel_out <= 4'h0;
    end else begin
      frame_pixel_out <= pix_next;
    end
  end

endmodule

// File: doc/frame_pixel_source.md
# frame_pixel_source

On-chip responder for the pixel-stream framebuffer interface. It receives the advance strobe (`frame_next_pixel`) and the restart level (`frame_reset`) that the VGA block drives toward the external framebuffer. It answers with a 4-bit gray pixel taken from an internal raster position and a selectable test pattern. It stands in for the RP2040 framebuffer in FPGA bring-up, self-test and loopback configurations, and connects pin-for-pin to the VGA block's frame port.

## Interface
Parameters:
- `WIDTH`, 160, pixels per line (≥2)
- `HEIGHT`, 120, lines per frame (≥2)
- `GRAD_SHIFT`, 3, right shift applied to x/y for the gradient patterns
- `CHK_BIT`, 3, coordinate bit that selects the checkerboard square (2^CHK_BIT px)

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `frame_next_pixel_in`  in  1  advance strobe from the VGA block; each rising edge consumes one pixel
- `frame_reset_in`  in  1  restart level from the VGA block; high holds the raster at (0,0)
- `pattern_sel`  in  3  pattern select, used directly without synchronisation
- `solid_level`  in  4  gray level for the solid patterns
- `frame_pixel_out`  out  4  current pixel to the VGA block's `frame_pixel_in`
- `frame_done`  out  1  one-cycle pulse when the last pixel of a frame is consumed

## Operation
- Both frame inputs pass through 2-flop synchronisers (s1→s2). `frame_next_pixel_in` has a third flop, s3, for edge detection.
  - `adv = s2 & ~s3`.
  - `rst_frm = s2` of `frame_reset_in`.
- Raster state:
  - x: clog2(WIDTH) bits
  - y: clog2(HEIGHT) bits
  - `frame_cnt`: 4 bits, wraps at 15
- Counter update, in priority order:
  - `rst_frm`: x=0, y=0. `adv` is ignored. `frame_cnt` is held. No `frame_done`.
  - else `adv` with x<WIDTH-1: x+1.
  - else `adv` with x=WIDTH-1, y<HEIGHT-1: x=0, y+1.
  - else `adv` at (WIDTH-1, HEIGHT-1): x=0, y=0, `frame_cnt`+1, `frame_done`=1 for one cycle.
  - otherwise: hold.
- Pattern function p(x,y), where all arithmetic is truncated to 4 bits:
  - 0: `solid_level`
  - 1: (x >> GRAD_SHIFT)[3:0]
  - 2: (y >> GRAD_SHIFT)[3:0]
  - 3: (x[CHK_BIT] ^ y[CHK_BIT]) ? 4'hF : 4'h0
  - 4: (x + y + frame_cnt)[3:0], a diagonal that scrolls one step per frame
  - 5: 4'hF if x==0, x==WIDTH-1, y==0 or y==HEIGHT-1; else 4'h0
  - 6: (x ^ y)[3:0]
  - 7: ~`solid_level`
- `frame_pixel_out` is a register loaded with p(x,y) of the current x/y/`frame_cnt`/`pattern_sel` on every clk edge.
- Reset (`rst_n` low, at any time, including mid-line or mid-frame): asynchronously clears all synchroniser flops, x, y, `frame_cnt`, `frame_pixel_out` (4'h0) and `frame_done` (0).

## Timing
- Advance latency, with E1 = first clk edge sampling `frame_next_pixel_in` high:
  - E2: s2=1.
  - E3: x/y update.
  - E4: `frame_pixel_out` shows the next pixel.
- `frame_done` rises on E3 of the wrapping advance.
- The strobe must stay high ≥2 clk and low ≥2 clk to be counted exactly once. Only one advance is counted per rising edge; a level held high never counts twice.
- Restart latency: `frame_reset_in` high → x=y=0 at E3 → `frame_pixel_out`=p(0,0) at E4.
- If `adv` and `rst_frm` are true in the same cycle, reset wins and the advance is lost.
- A `pattern_sel` or `solid_level` change is visible on `frame_pixel_out` after 1 clk edge.
- After `rst_n` deassertion the first valid p(0,0) appears at the first clk edge; no strobe is needed.

## Test plan
- Reset and solid pattern:
  - Assert `rst_n`=0 mid-frame → all outputs 0 immediately.
  - Release with `pattern_sel`=0, `solid_level`=9 → `frame_pixel_out`=9 after 1 edge.
- Horizontal gradient, default parameters, `pattern_sel`=1:
  - 40 strobes, each 2 clk high / 2 clk low.
  - Pixel after strobe k equals (k>>3)&15, appearing 3 edges after the synchronised rise.
  - After 40 strobes the output is 5.
- Line and frame wrap:
  - 159 strobes → x=159, y=0. One more → x=0, y=1.
  - 19200 strobes total → exactly one `frame_done` pulse, on the last strobe. x=y=0, `frame_cnt`=1.
  - With `pattern_sel`=4 the output at (0,0) becomes 1.
- Restart priority:
  - Hold `frame_reset_in` high while strobing 10 times → x stays 0, output stays p(0,0).
  - Drop `frame_reset_in`, then strobe once → raster moves to x=1.
- Long strobe:
  - Hold `frame_next_pixel_in` high for 50 clk → x advances by exactly 1.
- Checkerboard (`pattern_sel`=3):
  - (7,0)=0, (8,0)=15, (8,8)=0.
- Border (`pattern_sel`=5):
  - (0,5)=15, (1,5)=0.
